// File: rtl/hack_n2t_pkg.sv
// Shared types and constants for the Hack datapath word distributor.
package hack_n2t_pkg;

  typedef logic [15:0] word_t;
  typedef logic [1:0]  lane_sel_t;

  localparam int        NUM_LANES = 4;
  localparam lane_sel_t LANE_A    = 2'd0;
  localparam lane_sel_t LANE_B    = 2'd1;
  localparam lane_sel_t LANE_C    = 2'd2;
  localparam lane_sel_t LANE_D    = 2'd3;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } lane_state_t;

endpackage

// File: rtl/demux_lane_16bits.sv
// One output lane: one-entry word buffer with valid/ready handshake.
// Optional delivered-word counter when DEMUX_STATS_EN is defined.
//
// state | meaning
// EMPTY | no word held; data_o keeps the last word (0 after reset)
// FULL  | word held and presented with valid_o high
module demux_lane_16bits
  import hack_n2t_pkg::*;
(
  input  logic  clk_in,
  input  logic  rst_n_in,
  input  logic  load_i,
  input  word_t data_i,
  input  logic  ready_i,
  output word_t data_o,
  output logic  valid_o,
  output logic  empty_o
`ifdef DEMUX_STATS_EN
  ,
  output word_t count_o
`endif
);

  lane_state_t state_q, state_d;
  word_t       data_q, data_d;
  logic        handshake;

  assign handshake = (state_q == FULL) && ready_i;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  // A load while draining replaces the word in place, so there is no bubble.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (load_i) begin
      data_d = data_i;
    end
    case (state_q)
      EMPTY: if (load_i) state_d = FULL;
      FULL: begin
        if (load_i)         state_d = FULL;
        else if (handshake) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  assign data_o  = data_q;
  assign valid_o = (state_q == FULL);
  assign empty_o = (state_q == EMPTY);

`ifdef DEMUX_STATS_EN
  word_t count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (handshake) count_d = count_q + 16'd1;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) count_q <= '0;
    else           count_q <= count_d;
  end

  assign count_o = count_q;
`endif

endmodule

// File: rtl/demux_1x4_16bits_buffered.sv
// Registered 1-to-4 word distributor with per-lane buffering and handshakes.
// Optional per-lane delivered-word counters when DEMUX_STATS_EN is defined.
module demux_1x4_16bits_buffered
  import hack_n2t_pkg::*;
(
  input  logic      clk_in,
  input  logic      rst_n_in,
  input  word_t     data_in,
  input  lane_sel_t sel_in,
  input  logic      valid_in,
  output logic      ready_out,
  output word_t     a_out,
  output word_t     b_out,
  output word_t     c_out,
  output word_t     d_out,
  output logic      a_valid_out,
  output logic      b_valid_out,
  output logic      c_valid_out,
  output logic      d_valid_out,
  input  logic      a_ready_in,
  input  logic      b_ready_in,
  input  logic      c_ready_in,
  input  logic      d_ready_in
`ifdef DEMUX_STATS_EN
  ,
  output word_t     count_a_out,
  output word_t     count_b_out,
  output word_t     count_c_out,
  output word_t     count_d_out
`endif
);

  logic [NUM_LANES-1:0] lane_ready;
  logic [NUM_LANES-1:0] lane_empty;
  logic [NUM_LANES-1:0] lane_valid;
  logic [NUM_LANES-1:0] lane_load;
  word_t                lane_data [NUM_LANES];
  logic                 accept;

  assign lane_ready = {d_ready_in, c_ready_in, b_ready_in, a_ready_in};

  // Only the addressed lane gates acceptance; valid_in is deliberately excluded.
  assign ready_out = lane_empty[sel_in] | lane_ready[sel_in];
  assign accept    = valid_in & ready_out;

  always_comb begin
    lane_load = '0;
    if (accept) begin
      case (sel_in)
        LANE_A:  lane_load[0] = 1'b1;
        LANE_B:  lane_load[1] = 1'b1;
        LANE_C:  lane_load[2] = 1'b1;
        LANE_D:  lane_load[3] = 1'b1;
        default: lane_load    = '0;
      endcase
    end
  end

`ifdef DEMUX_STATS_EN
  word_t lane_count [NUM_LANES];
`endif

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    demux_lane_16bits u_lane (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .load_i   (lane_load[i]),
      .data_i   (data_in),
      .ready_i  (lane_ready[i]),
      .data_o   (lane_data[i]),
      .valid_o  (lane_valid[i]),
      .empty_o  (lane_empty[i])
`ifdef DEMUX_STATS_EN
      ,
      .count_o  (lane_count[i])
`endif
    );
  end

  assign a_out       = lane_data[0];
  assign b_out       = lane_data[1];
  assign c_out       = lane_data[2];
  assign d_out       = lane_data[3];
  assign a_valid_out = lane_valid[0];
  assign b_valid_out = lane_valid[1];
  assign c_valid_out = lane_valid[2];
  assign d_valid_out = lane_valid[3];

`ifdef DEMUX_STATS_EN
  assign count_a_out = lane_count[0];
  assign count_b_out = lane_count[1];
  assign count_c_out = lane_count[2];
  assign count_d_out = lane_count[3];
`endif

endmodule

// File: tb/tb_demux_1x4_16bits_buffered.sv
// Bench for demux_1x4_16bits_buffered: directed table, hand sequences, and
// random traffic against a per-lane occupancy model. Counter checks need DEMUX_STATS_EN.
module tb_demux_1x4_16bits_buffered;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic [15:0] data_in = '0;
  logic [1:0]  sel_in = '0;
  logic        valid_in = 1'b0;
  logic        ready_out;
  logic [15:0] a_out, b_out, c_out, d_out;
  logic        a_valid_out, b_valid_out, c_valid_out, d_valid_out;
  logic        a_ready_in = 1'b0, b_ready_in = 1'b0, c_ready_in = 1'b0, d_ready_in = 1'b0;
`ifdef DEMUX_STATS_EN
  logic [15:0] count_a_out, count_b_out, count_c_out, count_d_out;
`endif

  demux_1x4_16bits_buffered dut (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .data_in     (data_in),
    .sel_in      (sel_in),
    .valid_in    (valid_in),
    .ready_out   (ready_out),
    .a_out       (a_out),
    .b_out       (b_out),
    .c_out       (c_out),
    .d_out       (d_out),
    .a_valid_out (a_valid_out),
    .b_valid_out (b_valid_out),
    .c_valid_out (c_valid_out),
    .d_valid_out (d_valid_out),
    .a_ready_in  (a_ready_in),
    .b_ready_in  (b_ready_in),
    .c_ready_in  (c_ready_in),
    .d_ready_in  (d_ready_in)
`ifdef DEMUX_STATS_EN
    ,
    .count_a_out (count_a_out),
    .count_b_out (count_b_out),
    .count_c_out (count_c_out),
    .count_d_out (count_d_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  // Reference model: what each lane holds and how many words it has delivered.
  logic        m_full [4];
  logic [15:0] m_data [4];
  logic [15:0] m_cnt  [4];

  typedef struct {
    logic [1:0]  sel;
    logic [15:0] data;
    logic        valid;
    logic [3:0]  rdy;       // bit0 = lane a
    logic        exp_ready; // before the edge
    logic [3:0]  exp_vmask; // after the edge, bit0 = lane a
    int          chk_lane;
    logic [15:0] exp_data;  // lane chk_lane after the edge
  } vec_t;

  function automatic logic [3:0] vmask();
    return {d_valid_out, c_valid_out, b_valid_out, a_valid_out};
  endfunction

  function automatic logic [15:0] lane_out(int i);
    case (i)
      0: return a_out;
      1: return b_out;
      2: return c_out;
      default: return d_out;
    endcase
  endfunction

`ifdef DEMUX_STATS_EN
  function automatic logic [15:0] lane_cnt(int i);
    case (i)
      0: return count_a_out;
      1: return count_b_out;
      2: return count_c_out;
      default: return count_d_out;
    endcase
  endfunction
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_full[i] = 1'b0;
      m_data[i] = '0;
      m_cnt[i]  = '0;
    end
  endtask

  task automatic check_model(input logic [1:0] s, input logic [3:0] r);
    check("ready_out", {31'd0, ready_out}, {31'd0, (!m_full[s]) || r[s]});
    for (int i = 0; i < 4; i++) begin
      check($sformatf("lane%0d_valid", i), {31'd0, vmask()[i]}, {31'd0, m_full[i]});
      check($sformatf("lane%0d_data", i), {16'd0, lane_out(i)}, {16'd0, m_data[i]});
`ifdef DEMUX_STATS_EN
      check($sformatf("lane%0d_count", i), {16'd0, lane_cnt(i)}, {16'd0, m_cnt[i]});
`endif
    end
  endtask

  // Drive one cycle's inputs, check against the model, advance across one edge.
  task automatic step(input logic [1:0] s, input logic [15:0] d, input logic v,
                      input logic [3:0] r, input logic do_check, output logic rdy_seen);
    logic acc;
    sel_in = s; data_in = d; valid_in = v;
    {d_ready_in, c_ready_in, b_ready_in, a_ready_in} = r;
    #2;
    rdy_seen = ready_out;
    if (do_check) check_model(s, r);
    acc = v && ((!m_full[s]) || r[s]);
    @(posedge clk_in);
    for (int i = 0; i < 4; i++) begin
      if (m_full[i] && r[i]) begin
        m_cnt[i]  = m_cnt[i] + 16'd1;
        m_full[i] = 1'b0;
      end
      if (acc && s == 2'(i)) begin
        m_full[i] = 1'b1;
        m_data[i] = d;
      end
    end
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk_in);
    rst_n_in = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_in);
    #3 rst_n_in = 1'b1;
    @(posedge clk_in);
    #1;
  endtask

  vec_t vecs [$];
  logic rs;

  initial begin
    vec_t v;
    model_reset();
    valid_in = 1'b0;
    apply_reset();

    // Reset state
    check("rst_ready", {31'd0, ready_out}, 32'd1);
    check("rst_vmask", {28'd0, vmask()}, 32'd0);
    check("rst_c_out", {16'd0, c_out}, 32'd0);

    // single word, stall isolation, drain
    vecs.push_back('{2'd2, 16'h1234, 1'b1, 4'b0000, 1'b1, 4'b0100, 2, 16'h1234});
    vecs.push_back('{2'd0, 16'h0000, 1'b0, 4'b0000, 1'b1, 4'b0100, 2, 16'h1234});
    vecs.push_back('{2'd0, 16'hAAAA, 1'b1, 4'b0000, 1'b1, 4'b0101, 0, 16'hAAAA});
    vecs.push_back('{2'd0, 16'hBBBB, 1'b1, 4'b0000, 1'b0, 4'b0101, 0, 16'hAAAA});
    vecs.push_back('{2'd1, 16'hBBBB, 1'b1, 4'b0000, 1'b1, 4'b0111, 1, 16'hBBBB});
    vecs.push_back('{2'd0, 16'h0000, 1'b0, 4'b0000, 1'b0, 4'b0111, 0, 16'hAAAA});
    vecs.push_back('{2'd3, 16'h0000, 1'b0, 4'b1111, 1'b1, 4'b0000, 2, 16'h1234});
    // back-to-back replace on lane d
    for (int k = 1; k <= 8; k++)
      vecs.push_back('{2'd3, 16'(k), 1'b1, 4'b1000, 1'b1, 4'b1000, 3, 16'(k)});
    vecs.push_back('{2'd3, 16'h0000, 1'b0, 4'b1000, 1'b1, 4'b0000, 3, 16'h0008});

    foreach (vecs[i]) begin
      v = vecs[i];
      step(v.sel, v.data, v.valid, v.rdy, 1'b1, rs);
      check($sformatf("vec%0d_ready", i), {31'd0, rs}, {31'd0, v.exp_ready});
      check($sformatf("vec%0d_vmask", i), {28'd0, vmask()}, {28'd0, v.exp_vmask});
      check($sformatf("vec%0d_data", i), {16'd0, lane_out(v.chk_lane)}, {16'd0, v.exp_data});
    end

    // Random traffic; readies biased high so lanes both fill and drain
    for (int n = 0; n < 400; n++) begin
      logic [3:0] r;
      for (int i = 0; i < 4; i++) r[i] = ($urandom_range(0, 3) != 0);
      step(2'($urandom_range(0, 3)), 16'($urandom), 1'($urandom_range(0, 1)), r, 1'b1, rs);
    end

    // Reset mid-operation: fill all lanes with readies low, then async reset
    for (int i = 0; i < 4; i++)
      step(2'(i), 16'h00A0 + 16'(i), 1'b1, 4'b0000, 1'b1, rs);
    check("fill_vmask", {28'd0, vmask()}, 32'hF);
    check("fill_d_out", {16'd0, d_out}, 32'h00A3);
    valid_in = 1'b0;
    #2 rst_n_in = 1'b0;
    model_reset();
    #1;
    check("async_vmask", {28'd0, vmask()}, 32'd0);
    check("async_data", {a_out | b_out | c_out | d_out, 16'd0}, 32'd0);
    @(posedge clk_in);
    #3 rst_n_in = 1'b1;
    @(posedge clk_in);
    #1;
    sel_in = 2'd2;
    #1;
    check("post_rst_ready", {31'd0, ready_out}, 32'd1);
    check("post_rst_a_out", {16'd0, a_out}, 32'd0);
    #1;

`ifdef DEMUX_STATS_EN
    begin : wrap_test
      int budget;
      budget = 0;
      while (m_cnt[1] != 16'hFFFF && budget < 70000) begin
        step(2'd1, 16'(budget), 1'b1, 4'b0010, 1'b0, rs);
        budget++;
      end
      check("wrap_budget", {31'd0, m_cnt[1] == 16'hFFFF}, 32'd1);
      check("count_b_ffff", {16'd0, count_b_out}, 32'h0000FFFF);
      check("count_a_zero", {16'd0, count_a_out | count_c_out | count_d_out}, 32'd0);
      step(2'd1, 16'h5555, 1'b0, 4'b0010, 1'b1, rs);
      check("count_b_wrap", {16'd0, count_b_out}, 32'd0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_1x4_16bits_buffered.md
# demux_1x4_16bits_buffered

Registered 1-to-4 word distributor for the Hack processor datapath, the write-side counterpart of the 4:1 16-bit selector tree. A single 16-bit source word with a 2-bit destination select is routed to one of four output lanes. Each lane holds the word in a one-entry buffer under an independent valid/ready handshake, so a stalled lane blocks only traffic addressed to that lane.

## Interface
- No parameters. Width is fixed at 16 bits and lane count at 4.
- clk_in  input  1  sole clock; all state is updated on the rising edge.
- rst_n_in  input  1  asynchronous, active-low reset.
- data_in  input  16  source word.
- sel_in  input  2  destination lane: 0=a, 1=b, 2=c, 3=d.
- valid_in  input  1  source word and sel_in are valid.
- ready_out  output  1  block accepts the word this cycle.
- a_out, b_out, c_out, d_out  output  16 each  lane data, registered.
- a_valid_out, b_valid_out, c_valid_out, d_valid_out  output  1 each  lane holds a word.
- a_ready_in, b_ready_in, c_ready_in, d_ready_in  input  1 each  lane consumer takes the word.
- count_a_out, count_b_out, count_c_out, count_d_out  output  16 each  delivered-word counters. Present only with DEMUX_STATS_EN.

## Operation
- Each lane has two states: EMPTY and FULL.
- EMPTY -> FULL: input accepted with sel_in equal to the lane.
- FULL -> EMPTY: lane valid and lane ready are both high, and no new word for that lane is accepted in the same cycle.
- FULL -> FULL with replace: lane is draining and a new word for the same lane is accepted in the same cycle. The lane register loads the new word. There is no bubble.
- ready_out = lane_empty[sel_in] OR lane_ready[sel_in], taken from the addressed lane only. It is combinational from sel_in and lane ready. It does not depend on valid_in.
- Accept occurs when valid_in AND ready_out are both high.
- Only the addressed lane loads. The other lanes keep their data and drain independently.
- Lane data registers load only on accept. Their contents while EMPTY are the last word held, or 0 after reset.
- A source may change sel_in while valid_in is high and ready_out is low. The newly addressed lane's readiness then applies in that same cycle.
- Reset at any time, including mid-transfer: all lanes return to EMPTY, valid outputs go to 0, data outputs go to 0, and counters go to 0. In-flight words are discarded.

## Timing
- Latency is 1 cycle. A word accepted at edge N shows on its lane data with lane valid high after edge N.
- Throughput is one word per cycle per lane, sustained while the consumer holds lane ready high.
- No output data or valid bit is combinational from the inputs. Only ready_out is combinational.
- Reset values: all *_valid_out = 0, all lane data = 16'h0000, all count_*_out = 16'h0000. ready_out = 1 after reset, because every lane is EMPTY.

## Configuration
- Macro: DEMUX_STATS_EN.
- When defined:
  - Each lane has a 16-bit counter that increments on every lane handshake (valid AND ready).
  - Counters wrap from 16'hFFFF to 16'h0000 silently.
  - Counters are exposed on the count_*_out ports.
- When undefined: the counter ports and counter logic are absent, and handshake behaviour is identical.

## Structure
- Shared package hack_n2t_pkg holds:
  - typedef word_t (logic [15:0]);
  - typedef lane_sel_t (logic [1:0]);
  - constant LANE_A..LANE_D = 2'd0..2'd3;
  - enum lane_state_t {EMPTY, FULL}.
- Sub-module demux_lane_16bits implements one lane: buffer, state, and the optional counter.
  - Instantiate it four times.
  - Top-level logic is limited to decoding sel_in into per-lane load enables and selecting ready_out.

## Test plan
- Reset then single word: reset, then data_in=16'h1234 with sel_in=2 and valid_in=1 for one cycle. Required: ready_out=1 throughout; after the next edge c_valid_out=1 and c_out=16'h1234; other lane valids stay 0.
- Stall isolation:
  - Hold a_ready_in=0.
  - Send 16'hAAAA to lane 0, then 16'hBBBB to lane 0. Required: ready_out=0 while the second word is pending.
  - Switch sel_in=1 with 16'hBBBB. Required: accepted at once; b_out=16'hBBBB next cycle; a_out stays 16'hAAAA.
- Back-to-back replace: d_ready_in=1 held, stream 16'h0001..16'h0008 to lane 3 on consecutive cycles. Required: ready_out=1 every cycle, and d_out shows 1..8 on consecutive cycles with no gap.
- Reset mid-operation:
  - Fill lanes 0–3 with 16'h00A0..16'h00A3, with all lane readies low.
  - Assert rst_n_in=0 asynchronously between edges. Required: all valid outputs and data outputs go to 0 immediately, and ready_out=1 after release.
- Stats wrap (DEMUX_STATS_EN): preload count_b via 65535 handshakes, then one more. Required: count_b_out reads 16'hFFFF, then 16'h0000; other counters stay 0.
- Build without DEMUX_STATS_EN: rerun the stall isolation and back-to-back replace scenarios. Required: identical handshake waveforms and no counter ports.
